// File: rtl/datapath_unit.sv
// Execution datapath for the six-instruction controller: register file, ALU,
// write-source mux and data memory with a debug preload port.
module datapath_unit #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4,
    parameter int D_AW   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [D_AW-1:0]   D_addr,
    input  logic              D_rd,
    input  logic              D_wr,
    input  logic [7:0]        RF_W_data,
    input  logic              RF_s1,
    input  logic              RF_s0,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic              RF_W_wr,
    input  logic [RF_AW-1:0]  RF_Rp_addr,
    input  logic              RF_Rp_rd,
    input  logic [RF_AW-1:0]  RF_Rq_addr,
    input  logic              RF_Rq_rd,
    input  logic              alu_s1,
    input  logic              alu_s0,
    input  logic              dbg_wr,
    input  logic [D_AW-1:0]   dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              RF_RP_zero,
    output logic [DATA_W-1:0] rp_data,
    output logic [CNT_W-1:0]  rf_wr_count
);

    localparam int N_REGS  = 1 << RF_AW;
    localparam int N_WORDS = 1 << D_AW;

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [CNT_W-1:0]  rf_wr_count_q, rf_wr_count_d;
    logic [DATA_W-1:0] mem_q [N_WORDS];

    logic [DATA_W-1:0] rq_data;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        rp_data    = RF_Rp_rd ? regs_q[RF_Rp_addr] : '0;
        rq_data    = RF_Rq_rd ? regs_q[RF_Rq_addr] : '0;
        RF_RP_zero = (rp_data == '0);
        mem_rdata  = D_rd ? mem_q[D_addr] : '0;
    end

    always_comb begin
        alu_out = '0;
        case ({alu_s1, alu_s0})
            2'b00:   alu_out = rp_data;
            2'b01:   alu_out = rp_data + rq_data;
            2'b10:   alu_out = rp_data - rq_data;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        w_data = alu_out;
        case ({RF_s1, RF_s0})
            2'b01:   w_data = mem_rdata;
            2'b10:   w_data = {{(DATA_W-8){1'b0}}, RF_W_data};
            default: w_data = alu_out;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (RF_W_wr) begin
            regs_d[RF_W_addr] = w_data;
        end
    end

    // Saturating so a long verification run never wraps back to small values.
    always_comb begin
        rf_wr_count_d = rf_wr_count_q;
        if (RF_W_wr && (rf_wr_count_q != '1)) begin
            rf_wr_count_d = rf_wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rf_wr_count_q <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rf_wr_count_q <= rf_wr_count_d;
        end
    end

    // Memory has no reset; the debug write is ordered last so it wins a collision.
    always_ff @(posedge clk) begin
        if (D_wr) begin
            mem_q[D_addr] <= rp_data;
        end
        if (dbg_wr) begin
            mem_q[dbg_addr] <= dbg_data;
        end
    end

    assign rf_wr_count = rf_wr_count_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed-vector bench for datapath_unit; expected values are hand-computed.
module tb_datapath_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  D_addr;
    logic        D_rd, D_wr;
    logic [7:0]  RF_W_data;
    logic        RF_s1, RF_s0;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        RF_Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        RF_Rq_rd;
    logic        alu_s1, alu_s0;
    logic        dbg_wr;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        RF_RP_zero;
    logic [15:0] rp_data;
    logic [15:0] rf_wr_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    datapath_unit dut (
        .clk(clk), .reset(reset),
        .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .RF_W_data(RF_W_data), .RF_s1(RF_s1), .RF_s0(RF_s0),
        .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Rp_addr(RF_Rp_addr), .RF_Rp_rd(RF_Rp_rd),
        .RF_Rq_addr(RF_Rq_addr), .RF_Rq_rd(RF_Rq_rd),
        .alu_s1(alu_s1), .alu_s0(alu_s0),
        .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .RF_RP_zero(RF_RP_zero), .rp_data(rp_data), .rf_wr_count(rf_wr_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_p(input logic [3:0] a);
        RF_Rp_addr = a;
        RF_Rp_rd   = 1'b1;
        #1;
    endtask

    // One register write: source {s1,s0}, constant k, ALU op on P=pa, Q=qa, memory address da.
    task automatic do_write(input logic [3:0] wa, input logic [1:0] src, input logic [7:0] k,
                            input logic [1:0] op, input logic [3:0] pa, input logic [3:0] qa,
                            input logic [7:0] da);
        RF_W_addr  = wa;
        {RF_s1, RF_s0}   = src;
        RF_W_data  = k;
        {alu_s1, alu_s0} = op;
        RF_Rp_addr = pa;
        RF_Rp_rd   = 1'b1;
        RF_Rq_addr = qa;
        RF_Rq_rd   = 1'b1;
        D_addr     = da;
        D_rd       = 1'b1;
        RF_W_wr    = 1'b1;
        tick();
        RF_W_wr    = 1'b0;
        D_rd       = 1'b0;
        if (exp_cnt < 16'hFFFF) exp_cnt++;
    endtask

    task automatic load_mem(input logic [3:0] wa, input logic [7:0] da);
        do_write(wa, 2'b01, 8'h00, 2'b00, 4'd0, 4'd0, da);
    endtask

    initial begin
        reset = 1'b1;
        D_addr = '0; D_rd = 0; D_wr = 0; RF_W_data = '0; RF_s1 = 0; RF_s0 = 0;
        RF_W_addr = '0; RF_W_wr = 0; RF_Rp_addr = '0; RF_Rp_rd = 0;
        RF_Rq_addr = '0; RF_Rq_rd = 0; alu_s1 = 0; alu_s0 = 0;
        dbg_wr = 0; dbg_addr = '0; dbg_data = '0;
        #1 reset = 1'b0;
        #1;
        check_val("rst_rp", rp_data, 16'h0000);
        check_val("rst_zero", RF_RP_zero, 1);
        check_val("rst_cnt", rf_wr_count, 0);

        // Debug preload while reset is held
        dbg_wr = 1; dbg_addr = 8'h10; dbg_data = 16'h1234;
        tick();
        dbg_addr = 8'h50; dbg_data = 16'h7777;
        tick();
        dbg_wr = 0;
        reset = 1'b1;

        // Load_const, with same-cycle read returning the old value
        read_p(4'd3);
        RF_W_addr = 4'd3; RF_s1 = 1; RF_s0 = 0; RF_W_data = 8'hA5; RF_W_wr = 1;
        #1;
        check_val("lc_old", rp_data, 16'h0000);
        tick();
        RF_W_wr = 0; exp_cnt++;
        read_p(4'd3);
        check_val("lc_r3", rp_data, 16'h00A5);
        check_val("lc_cnt", rf_wr_count, 1);

        // Load then Store
        load_mem(4'd1, 8'h10);
        read_p(4'd1);
        check_val("load_r1", rp_data, 16'h1234);
        RF_Rp_addr = 4'd1; RF_Rp_rd = 1; D_wr = 1; D_addr = 8'h20;
        tick();
        D_wr = 0;
        load_mem(4'd6, 8'h20);
        read_p(4'd6);
        check_val("store_m20", rp_data, 16'h1234);

        // Arithmetic wrap: r7=1, r1=r0-r7=FFFF, r2=2, r3=r1+r2, r4=r2-r1
        do_write(4'd7, 2'b10, 8'h01, 2'b00, 4'd0, 4'd0, 8'h00);
        do_write(4'd1, 2'b00, 8'h00, 2'b10, 4'd0, 4'd7, 8'h00);
        read_p(4'd1);
        check_val("sub_r1", rp_data, 16'hFFFF);
        do_write(4'd2, 2'b10, 8'h02, 2'b00, 4'd0, 4'd0, 8'h00);
        do_write(4'd3, 2'b00, 8'h00, 2'b01, 4'd1, 4'd2, 8'h00);
        read_p(4'd3);
        check_val("add_r3", rp_data, 16'h0001);
        do_write(4'd4, 2'b00, 8'h00, 2'b10, 4'd2, 4'd1, 8'h00);
        read_p(4'd4);
        check_val("sub_r4", rp_data, 16'h0003);
        do_write(4'd8, 2'b00, 8'h00, 2'b00, 4'd2, 4'd1, 8'h00);
        read_p(4'd8);
        check_val("pass_r8", rp_data, 16'h0002);
        do_write(4'd9, 2'b10, 8'h55, 2'b00, 4'd0, 4'd0, 8'h00);
        do_write(4'd9, 2'b11, 8'h55, 2'b11, 4'd1, 4'd2, 8'h00);
        read_p(4'd9);
        check_val("zero_op_r9", rp_data, 16'h0000);
        do_write(4'd10, 2'b11, 8'h00, 2'b01, 4'd4, 4'd2, 8'h00);
        read_p(4'd10);
        check_val("src11_r10", rp_data, 16'h0005);
        check_val("cnt_mid", rf_wr_count, exp_cnt[15:0]);

        // Zero flag around a write to r5
        read_p(4'd5);
        check_val("zf_r5_0", RF_RP_zero, 1);
        RF_W_addr = 4'd5; RF_s1 = 1; RF_s0 = 0; RF_W_data = 8'h01; RF_W_wr = 1;
        #1;
        check_val("zf_wr_cycle", RF_RP_zero, 1);
        tick();
        RF_W_wr = 0; exp_cnt++;
        #1;
        check_val("zf_after", RF_RP_zero, 0);
        check_val("zf_rp", rp_data, 16'h0001);
        RF_Rp_rd = 0;
        #1;
        check_val("zf_rd_off", RF_RP_zero, 1);

        // Debug/D_wr collision on one address, and disjoint addresses
        RF_Rp_addr = 4'd1; RF_Rp_rd = 1; D_wr = 1; D_addr = 8'h40;
        dbg_wr = 1; dbg_addr = 8'h40; dbg_data = 16'hBEEF;
        tick();
        RF_Rp_addr = 4'd3; D_addr = 8'h41; dbg_addr = 8'h42; dbg_data = 16'h4242;
        tick();
        D_wr = 0; dbg_wr = 0;
        load_mem(4'd11, 8'h40);
        read_p(4'd11);
        check_val("coll_m40", rp_data, 16'hBEEF);
        load_mem(4'd11, 8'h41);
        read_p(4'd11);
        check_val("dual_m41", rp_data, 16'h0001);
        load_mem(4'd11, 8'h42);
        read_p(4'd11);
        check_val("dual_m42", rp_data, 16'h4242);

        // Read and write of the same word in one cycle: read sees old data
        RF_Rp_addr = 4'd2; RF_Rp_rd = 1; D_wr = 1; D_rd = 1; D_addr = 8'h41;
        RF_W_addr = 4'd12; RF_s1 = 0; RF_s0 = 1; RF_W_wr = 1;
        tick();
        D_wr = 0; D_rd = 0; RF_W_wr = 0; exp_cnt++;
        read_p(4'd12);
        check_val("rw_old", rp_data, 16'h0001);
        load_mem(4'd12, 8'h41);
        read_p(4'd12);
        check_val("rw_new", rp_data, 16'h0002);

        // Asynchronous reset between edges with a register write and D_wr pending
        RF_W_addr = 4'd13; RF_s1 = 1; RF_s0 = 0; RF_W_data = 8'h77; RF_W_wr = 1;
        RF_Rp_addr = 4'd3; RF_Rp_rd = 1; D_wr = 1; D_addr = 8'h50;
        #2 reset = 1'b0;
        #1;
        check_val("mid_rst_rp", rp_data, 16'h0000);
        check_val("mid_rst_zero", RF_RP_zero, 1);
        check_val("mid_rst_cnt", rf_wr_count, 0);
        exp_cnt = 0;
        tick();
        RF_W_wr = 0; D_wr = 0;
        reset = 1'b1;
        read_p(4'd13);
        check_val("mid_rst_r13", rp_data, 16'h0000);
        read_p(4'd4);
        check_val("mid_rst_r4", rp_data, 16'h0000);
        load_mem(4'd14, 8'h50);
        read_p(4'd14);
        check_val("mid_rst_m50", rp_data, 16'h0000);
        check_val("post_rst_cnt", rf_wr_count, 1);

        // Saturation: run the counter up to FFFE, then three more writes
        RF_W_addr = 4'd15; RF_s1 = 1; RF_s0 = 0; RF_W_data = 8'h00; RF_W_wr = 1;
        repeat (16'hFFFE - exp_cnt) @(posedge clk);
        #1;
        RF_W_wr = 0;
        check_val("sat_fffe", rf_wr_count, 16'hFFFE);
        exp_cnt = 16'hFFFE;
        do_write(4'd15, 2'b10, 8'h01, 2'b00, 4'd0, 4'd0, 8'h00);
        check_val("sat_ffff", rf_wr_count, 16'hFFFF);
        do_write(4'd15, 2'b10, 8'h02, 2'b00, 4'd0, 4'd0, 8'h00);
        do_write(4'd15, 2'b10, 8'h03, 2'b00, 4'd0, 4'd0, 8'h00);
        check_val("sat_hold", rf_wr_count, 16'hFFFF);
        read_p(4'd15);
        check_val("sat_r15", rp_data, 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
